// File: rtl/karaoke_pkg.sv
// rtl/karaoke_pkg.sv - shared PCM types and FIFO defaults for the karaoke audio path
package karaoke_pkg;

  localparam int PCM_W          = 16;
  localparam int FIFO_DEPTH     = 64;
  localparam int FIFO_WATERMARK = 32;
  localparam int DROP_CNT_W     = 16;

  typedef logic signed [PCM_W-1:0] pcm_t;

endpackage

// File: rtl/pcm_fifo_mem.sv
// rtl/pcm_fifo_mem.sv - simple dual-port sample RAM with registered read
module pcm_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // No reset so the array and read register map onto block RAM; a same-address
  // read during write returns the old word, which the full push+pop case relies on.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/pcm_fifo.sv
// rtl/pcm_fifo.sv - elastic PCM sample buffer between decimator and SPI transmitter
module pcm_fifo
  import karaoke_pkg::*;
#(
  parameter int DATA_W    = PCM_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int WATERMARK = FIFO_WATERMARK
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        in_sample,
  input  logic                     in_valid,
  input  logic                     pop,
  output logic [DATA_W-1:0]        out_sample,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     irq,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     flags_clr,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PW-1:0]         w_wr_ptr_nxt, w_rd_ptr_nxt, w_level_nxt;
  logic [PW-1:0]         r_level;
  logic                  r_empty, r_full, r_irq;
  logic                  r_out_valid, r_rd_seen;
  logic                  r_overflow, r_underflow;
  logic [DROP_CNT_W-1:0] r_drop_count;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  w_pop_ok, w_push_ok, w_drop, w_underrun;

  // Empty is judged before any same-cycle push; a pop at full frees room for the push.
  assign w_pop_ok   = pop && !r_empty;
  assign w_push_ok  = in_valid && (!r_full || w_pop_ok);
  assign w_drop     = in_valid && !w_push_ok;
  assign w_underrun = pop && r_empty;

  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push_ok);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop_ok);
  assign w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_irq        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_rd_seen    <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_level     <= w_level_nxt;
      r_empty     <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full      <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                     (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
      r_irq       <= (w_level_nxt >= PW'(WATERMARK));
      r_out_valid <= w_pop_ok;
      if (w_pop_ok) r_rd_seen <= 1'b1;

      // A new event in the same cycle as a clear takes priority over the clear.
      if (w_drop)         r_overflow <= 1'b1;
      else if (flags_clr) r_overflow <= 1'b0;

      if (w_underrun)     r_underflow <= 1'b1;
      else if (flags_clr) r_underflow <= 1'b0;

      if (flags_clr)                          r_drop_count <= DROP_CNT_W'(w_drop);
      else if (w_drop && r_drop_count != '1)  r_drop_count <= r_drop_count + 1'b1;
    end
  end

  pcm_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push_ok),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (in_sample),
    .i_rd_en   (w_pop_ok),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // The RAM read register has no reset, so mask it until the first real read.
  assign out_sample = r_rd_seen ? w_rd_data : '0;
  assign out_valid  = r_out_valid;
  assign level      = r_level;
  assign empty      = r_empty;
  assign full       = r_full;
  assign irq        = r_irq;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pcm_fifo.sv
// tb/tb_pcm_fifo.sv - randomized self-checking bench for pcm_fifo against a queue model
module tb_pcm_fifo;
  import karaoke_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;
  localparam int WM    = FIFO_WATERMARK;

  logic        clk, reset_n;
  pcm_t        in_sample;
  logic        in_valid, pop, flags_clr;
  logic [15:0] out_sample;
  logic        out_valid, empty, full, irq, overflow, underflow;
  logic [6:0]  level;
  logic [15:0] drop_count;

  pcm_fifo dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .pop        (pop),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .irq        (irq),
    .overflow   (overflow),
    .underflow  (underflow),
    .flags_clr  (flags_clr),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "init";

  logic [15:0] q[$];
  logic [15:0] m_out;
  bit          m_ovld, m_ov, m_un;
  int          m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    q.delete();
    m_out = '0; m_ovld = 0; m_ov = 0; m_un = 0; m_drop = 0;
  endtask

  task automatic model_apply(input bit iv, input logic [15:0] s, input bit p, input bit fc);
    int  sz;
    bit  pop_ok, push_ok, drop, und;
    sz      = q.size();
    pop_ok  = p && sz > 0;
    push_ok = iv && (sz < DEPTH || pop_ok);
    drop    = iv && !push_ok;
    und     = p && sz == 0;
    m_ovld  = pop_ok;
    if (pop_ok) m_out = q.pop_front();
    if (push_ok) q.push_back(s);
    if (fc) begin
      m_ov = 0; m_un = 0; m_drop = 0;
    end
    if (drop) begin
      m_ov = 1;
      if (m_drop < 'hFFFF) m_drop++;
    end
    if (und) m_un = 1;
  endtask

  task automatic check_model();
    chk({phase, ".level"},      32'(level),      32'(q.size()));
    chk({phase, ".empty"},      32'(empty),      32'(q.size() == 0));
    chk({phase, ".full"},       32'(full),       32'(q.size() == DEPTH));
    chk({phase, ".irq"},        32'(irq),        32'(q.size() >= WM));
    chk({phase, ".out_valid"},  32'(out_valid),  32'(m_ovld));
    chk({phase, ".out_sample"}, 32'(out_sample), 32'(m_out));
    chk({phase, ".overflow"},   32'(overflow),   32'(m_ov));
    chk({phase, ".underflow"},  32'(underflow),  32'(m_un));
    chk({phase, ".drop_count"}, 32'(drop_count), 32'(m_drop));
  endtask

  task automatic step(input bit iv, input logic [15:0] s, input bit p, input bit fc);
    in_valid = iv; in_sample = s; pop = p; flags_clr = fc;
    @(posedge clk);
    model_apply(iv, s, p, fc);
    #1;
    in_valid = 0; pop = 0; flags_clr = 0;
    check_model();
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 2 * DEPTH) begin
      step(0, '0, 1, 0);
      guard++;
    end
  endtask

  initial begin
    reset_n = 0; in_valid = 0; pop = 0; flags_clr = 0; in_sample = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    phase = "reset";
    check_model();
    reset_n = 1;

    phase = "basic";
    for (int i = 1; i <= 5; i++) step(1, 16'(i), 0, 0);
    chk("basic.level5", 32'(level), 32'd5);
    for (int i = 1; i <= 5; i++) begin
      step(0, '0, 1, 0);
      chk("basic.order", 32'(out_sample), 32'(i));
    end
    chk("basic.empty_after", 32'(empty), 32'd1);

    phase = "irq";
    for (int i = 0; i < WM; i++) step(1, 16'h0100 + 16'(i), 0, 0);
    chk("irq.rise", 32'(irq), 32'd1);
    step(0, '0, 1, 0);
    chk("irq.fall", 32'(irq), 32'd0);
    drain();

    phase = "overflow";
    for (int i = 0; i < DEPTH + 3; i++) step(1, 16'h0200 + 16'(i), 0, 0);
    chk("overflow.drops", 32'(drop_count), 32'd3);
    chk("overflow.level", 32'(level), 32'(DEPTH));
    drain();

    phase = "full_pushpop";
    for (int i = 0; i < DEPTH; i++) step(1, 16'h0300 + 16'(i), 0, 0);
    step(1, 16'h0BAD, 1, 0);
    chk("full_pushpop.oldest", 32'(out_sample), 32'h0300);
    chk("full_pushpop.level", 32'(level), 32'(DEPTH));
    drain();

    phase = "underflow";
    step(0, '0, 1, 0);
    chk("underflow.flag", 32'(underflow), 32'd1);
    step(1, 16'h0444, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 16'h0500 + 16'(i), 0, 0);
    step(1, 16'h0DDD, 0, 1);
    chk("clr_vs_drop.drop_count", 32'(drop_count), 32'd1);
    chk("clr_vs_drop.underflow", 32'(underflow), 32'd0);
    drain();
    step(0, '0, 0, 1);

    phase = "random";
    for (int b = 0; b < 12; b++) begin
      int pw = $urandom_range(10, 90);
      int pp = $urandom_range(10, 90);
      for (int c = 0; c < 180; c++) begin
        step($urandom_range(0, 99) < pw, 16'($urandom),
             $urandom_range(0, 99) < pp, $urandom_range(0, 99) < 3);
      end
    end

    phase = "midreset";
    drain();
    for (int i = 0; i < 40; i++) step(1, 16'h0600 + 16'(i), 0, 0);
    reset_n = 0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #2;
    reset_n = 1;
    step(0, '0, 1, 0);
    chk("midreset.no_valid", 32'(out_valid), 32'd0);
    step(1, 16'hBEEF, 0, 0);
    step(0, '0, 1, 0);
    chk("midreset.fresh", 32'(out_sample), 32'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
